// File: rtl/reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_arbiter_pkg
// Shared types for the register-bus arbiter:
//   state_e    - arbiter FSM state (Idle, Busy)
//   reg_req_t  - default register-bus request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_t  - default register-bus response (rdata, error, ready)
// -----------------------------------------------------------------------------
package reg_arbiter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic {
        Idle = 1'b0,
        Busy = 1'b1
    } state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_arbiter_pick.sv
// -----------------------------------------------------------------------------
// reg_arbiter_pick
// Combinational rotating priority picker. The search starts at i_ptr and moves
// upward with wrap-around; the first set bit of i_valid wins.
// Ports:
//   i_valid [NumPorts] - request vector
//   i_ptr   [IdxW]     - index with highest priority (tie to 0 for fixed priority)
//   o_idx   [IdxW]     - winning index (0 when nothing is valid)
//   o_any              - at least one request is valid
// -----------------------------------------------------------------------------
module reg_arbiter_pick #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] i_valid,
    input  logic [IdxW-1:0]     i_ptr,
    output logic [IdxW-1:0]     o_idx,
    output logic                o_any
);

    // Rotated view: bit k corresponds to port (i_ptr + k) mod NumPorts.
    logic [NumPorts-1:0] w_rot;

    // i_ptr + off, wrapped into [0, NumPorts). One extra bit holds the carry.
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int off);
        logic [IdxW:0] s;
        s = {1'b0, base} + (IdxW+1)'(off);
        if (s >= (IdxW+1)'(NumPorts)) begin
            s = s - (IdxW+1)'(NumPorts);
        end
        return s[IdxW-1:0];
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_rot = NumPorts'({i_valid, i_valid} >> i_ptr);
        o_idx = '0;
        o_any = 1'b0;
        // Scan from the far end so the offset closest to i_ptr is written last.
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx = wrap_add(i_ptr, k);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
// Shares one register-bus slave port among NumPorts masters. One transaction at
// a time: a winner is picked in Idle, held through Busy until the slave raises
// ready, then an Idle bubble cycle follows.
// Build option:
//   REG_ARBITER_RR_EN defined   - round-robin arbitration
//   REG_ARBITER_RR_EN undefined - fixed priority, lowest valid index wins
// Ports:
//   clk_i, rst_ni          - clock (rising edge), async active-low reset
//   mst_req_i [NumPorts]   - master requests
//   mst_rsp_o [NumPorts]   - master responses (rdata/error broadcast, ready to winner)
//   slv_req_o              - request to the shared slave (valid only while Busy)
//   slv_rsp_i              - response from the shared slave
//   busy_o                 - a grant is active
//   gnt_idx_o              - current or most recent grant index
// -----------------------------------------------------------------------------
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 2,
    parameter type         req_t    = reg_req_t,
    parameter type         rsp_t    = reg_rsp_t,
    localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  req_t            mst_req_i [NumPorts],
    output rsp_t            mst_rsp_o [NumPorts],
    output req_t            slv_req_o,
    input  rsp_t            slv_rsp_i,
    output logic            busy_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    state_e              r_state;
    state_e              w_state_d;
    logic [IdxW-1:0]     r_gnt;
    logic [IdxW-1:0]     w_gnt_d;
    logic [NumPorts-1:0] w_valid;
    logic [IdxW-1:0]     w_pick_ptr;
    logic [IdxW-1:0]     w_win;
    logic                w_any;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NumPorts; i++) begin
            w_valid[i] = mst_req_i[i].valid;
        end
    end

    reg_arbiter_pick #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_pick (
        .i_valid (w_valid),
        .i_ptr   (w_pick_ptr),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

`ifdef REG_ARBITER_RR_EN
    // Round-robin: the port after the last winner gets top priority next time.
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_ptr_d;

    assign w_pick_ptr = r_ptr;

    always_comb begin
        w_ptr_d = r_ptr;
        if (r_state == Idle && w_any) begin
            w_ptr_d = (w_win == IdxW'(NumPorts - 1)) ? '0 : w_win + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end
`else
    assign w_pick_ptr = '0;
`endif

    // Next-state logic. Only the state leaves Busy on slave ready; the granted
    // master's valid is not consulted, so a misbehaving master cannot abort.
    always_comb begin
        w_state_d = r_state;
        w_gnt_d   = r_gnt;
        case (r_state)
            Idle: begin
                if (w_any) begin
                    w_state_d = Busy;
                    w_gnt_d   = w_win;
                end
            end
            Busy: begin
                if (slv_rsp_i.ready) begin
                    w_state_d = Idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            r_state <= Idle;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_gnt   <= w_gnt_d;
        end
    end

    // Request path depends only on master fields and registered state, never
    // on slv_rsp_i.
    always_comb begin
        slv_req_o       = mst_req_i[r_gnt];
        slv_req_o.valid = (r_state == Busy);
    end

    // rdata/error go to everyone; ready only reaches the granted port.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            mst_rsp_o[i]       = slv_rsp_i;
            mst_rsp_o[i].ready = (r_state == Busy) && (r_gnt == IdxW'(i)) && slv_rsp_i.ready;
        end
    end

    assign busy_o    = (r_state == Busy);
    assign gnt_idx_o = r_gnt;

    // The granted master must hold valid until the slave answers.
    a_hold_valid : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (r_state == Busy) |-> w_valid[r_gnt]
    );

endmodule

// File: tb/tb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_arbiter
// Bench for reg_arbiter with a 2-port and a 4-port instance. Expected grants
// come from a transaction-level model of the arbitration rule (fixed priority
// or round-robin, following REG_ARBITER_RR_EN).
// -----------------------------------------------------------------------------
module tb_reg_arbiter;
    import reg_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-port instance
    reg_req_t    m_req [2];
    reg_rsp_t    m_rsp [2];
    reg_req_t    s_req;
    reg_rsp_t    s_rsp;
    logic        busy;
    logic [0:0]  gnt;
    logic        slv_auto;
    logic        man_ready;
    logic        s_err;
    logic [31:0] s_rdata;

    // 4-port instance
    reg_req_t    m4_req [4];
    reg_rsp_t    m4_rsp [4];
    reg_req_t    s4_req;
    reg_rsp_t    s4_rsp;
    logic        busy4;
    logic [1:0]  gnt4;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;   // model pointer, 2-port
    int m_gnt  = 0;   // model last grant, 2-port
    int m4_ptr = 0;   // model pointer, 4-port

    // Zero-wait slave when slv_auto is set, otherwise bench-driven ready.
    always_comb begin
        s_rsp.rdata = s_rdata;
        s_rsp.error = s_err;
        s_rsp.ready = slv_auto ? s_req.valid : man_ready;
    end

    reg_arbiter #(.NumPorts(2)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mst_req_i (m_req),
        .mst_rsp_o (m_rsp),
        .slv_req_o (s_req),
        .slv_rsp_i (s_rsp),
        .busy_o    (busy),
        .gnt_idx_o (gnt)
    );

    reg_arbiter #(.NumPorts(4)) dut4 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mst_req_i (m4_req),
        .mst_rsp_o (m4_rsp),
        .slv_req_o (s4_req),
        .slv_rsp_i (s4_rsp),
        .busy_o    (busy4),
        .gnt_idx_o (gnt4)
    );

    // Arbitration rule: who wins among the set v of n ports, given pointer ptr.
    function automatic int pick(input logic [3:0] v, input int ptr, input int n);
        int idx;
`ifdef REG_ARBITER_RR_EN
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (v[2'(idx)]) return idx;
        end
`else
        for (int k = 0; k < n; k++) begin
            idx = k;
            if (v[2'(idx)]) return idx;
        end
        idx = ptr;
`endif
        return 0;
    endfunction

    function automatic int next_ptr(input int w, input int n);
`ifdef REG_ARBITER_RR_EN
        return (w == n - 1) ? 0 : w + 1;
`else
        return (w >= n) ? 0 : 0;
`endif
    endfunction

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) m_req[i] = '0;
        for (int i = 0; i < 4; i++) m4_req[i] = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        clear_masters();
        m_req[0].addr  = 32'h0000_00AA;
        m_req[0].wdata = 32'h0000_0055;
        m_req[1].valid = 1'b1;
        slv_auto  = 1'b0;
        man_ready = 1'b1;
        s_rdata   = 32'h0;
        s_err     = 1'b0;
        s4_rsp    = '0;
        repeat (2) @(negedge clk);
        checks++; if (s_req.valid !== 1'b0) begin errors++; $display("FAIL reset_slv_valid got=%0b exp=0", s_req.valid); end
        checks++; if (s_req.addr !== 32'hAA) begin errors++; $display("FAIL reset_slv_addr got=%0h exp=aa", s_req.addr); end
        checks++; if (s_req.wdata !== 32'h55) begin errors++; $display("FAIL reset_slv_wdata got=%0h exp=55", s_req.wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%0d exp=0", gnt); end
        checks++; if (m_rsp[0].ready !== 1'b0 || m_rsp[1].ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%0b%0b exp=00", m_rsp[1].ready, m_rsp[0].ready);
        end
        checks++; if (busy4 !== 1'b0 || gnt4 !== 2'd0) begin errors++; $display("FAIL reset_dut4 busy=%0b gnt=%0d exp=0/0", busy4, gnt4); end
        m_req[1].valid = 1'b0;
        man_ready = 1'b0;
        rst_n     = 1'b1;
        m_ptr  = 0;
        m_gnt  = 0;
        m4_ptr = 0;
    endtask

    // Port0 write, slave ready in cycle 4.
    task automatic test_single();
        @(posedge clk); #1;
        m_req[0] = '{addr: 32'h10, write: 1'b1, wdata: 32'hCAFE, wstrb: 4'hF, valid: 1'b1};
        for (int c = 0; c < 6; c++) begin
            if (c == 4) man_ready = 1'b1;
            if (c == 5) begin man_ready = 1'b0; m_req[0].valid = 1'b0; end
            @(negedge clk);
            checks++; if (s_req.valid !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL single_valid c=%0d got=%0b", c, s_req.valid); end
            checks++; if (m_rsp[0].ready !== (c == 4)) begin errors++; $display("FAIL single_p0_ready c=%0d got=%0b", c, m_rsp[0].ready); end
            checks++; if (m_rsp[1].ready !== 1'b0) begin errors++; $display("FAIL single_p1_ready c=%0d got=%0b exp=0", c, m_rsp[1].ready); end
            if (c == 1) begin
                checks++; if (s_req.addr !== 32'h10 || s_req.wdata !== 32'hCAFE || s_req.write !== 1'b1 || s_req.wstrb !== 4'hF) begin
                    errors++; $display("FAIL single_fields got addr=%0h wdata=%0h write=%0b wstrb=%0h", s_req.addr, s_req.wdata, s_req.write, s_req.wstrb);
                end
                checks++; if (gnt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_gnt got=%0d busy=%0b exp=0/1", gnt, busy); end
            end
            @(posedge clk); #1;
        end
        m_gnt = 0;
        m_ptr = next_ptr(0, 2);
    endtask

    task automatic test_read_routing();
        m_req[1] = '{addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        s_rdata  = 32'h1234_5678;
        s_err    = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_c0_busy got=%0b exp=0", busy); end
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL read_gnt got=%0d exp=1", gnt); end
        checks++; if (m_rsp[1].ready !== 1'b1 || m_rsp[1].rdata !== 32'h1234_5678 || m_rsp[1].error !== 1'b1) begin
            errors++; $display("FAIL read_p1 got ready=%0b rdata=%0h err=%0b exp 1/12345678/1", m_rsp[1].ready, m_rsp[1].rdata, m_rsp[1].error);
        end
        checks++; if (m_rsp[0].ready !== 1'b0) begin errors++; $display("FAIL read_p0_ready got=%0b exp=0", m_rsp[0].ready); end
        checks++; if (m_rsp[0].rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_p0_bcast got=%0h exp=12345678", m_rsp[0].rdata); end
        @(posedge clk); #1;
        m_req[1].valid = 1'b0;
        man_ready = 1'b0;
        s_err     = 1'b0;
        m_gnt = 1;
        m_ptr = next_ptr(1, 2);
    endtask

    // Both ports request continuously against a zero-wait slave.
    task automatic test_contention();
        int exp;
        slv_auto = 1'b1;
        m_req[0] = '{addr: 32'h100, write: 1'b1, wdata: 32'hA0, wstrb: 4'hF, valid: 1'b1};
        m_req[1] = '{addr: 32'h200, write: 1'b1, wdata: 32'hB1, wstrb: 4'hF, valid: 1'b1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (busy !== c[0]) begin errors++; $display("FAIL cont_busy c=%0d got=%0b exp=%0b", c, busy, c[0]); end
            if (c[0]) begin
                exp   = pick(4'b0011, m_ptr, 2);
                m_ptr = next_ptr(exp, 2);
                m_gnt = exp;
                checks++; if (gnt !== 1'(exp)) begin errors++; $display("FAIL cont_gnt c=%0d got=%0d exp=%0d", c, gnt, exp); end
                checks++; if (m_rsp[exp].ready !== 1'b1) begin errors++; $display("FAIL cont_ready c=%0d port=%0d got=0 exp=1", c, exp); end
            end
            @(posedge clk); #1;
        end
        m_req[0].valid = 1'b0;
        m_req[1].valid = 1'b0;
        slv_auto = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        m_req[1] = '{addr: 32'h30, write: 1'b1, wdata: 32'h33, wstrb: 4'h3, valid: 1'b1};
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b0;
        man_ready = 1'b1;
        m_req[0].addr  = 32'h44;
        m_req[1].valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 1'b0 || s_req.valid !== 1'b0) begin
            errors++; $display("FAIL midrst_state got busy=%0b gnt=%0d valid=%0b exp 0/0/0", busy, gnt, s_req.valid);
        end
        checks++; if (s_req.addr !== 32'h44) begin errors++; $display("FAIL midrst_addr got=%0h exp=44", s_req.addr); end
        checks++; if (m_rsp[0].ready !== 1'b0 || m_rsp[1].ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready got=%0b%0b exp=00", m_rsp[1].ready, m_rsp[0].ready);
        end
        @(negedge clk);
        man_ready = 1'b0;
        rst_n     = 1'b1;
        m_ptr = 0;
        m_gnt = 0;
        m4_ptr = 0;
        @(posedge clk); #1;
        m_req[0] = '{addr: 32'h50, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        m_req[1] = '{addr: 32'h60, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        // Two transactions: the first winner is served, then the other port.
        for (int t = 0; t < 2; t++) begin
            int exp;
            logic [3:0] v;
            v = {2'b00, m_req[1].valid, m_req[0].valid};
            exp = pick(v, m_ptr, 2);
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL postrst_idle t=%0d got=%0b exp=0", t, busy); end
            @(posedge clk); #1;
            man_ready = 1'b1;
            @(negedge clk);
            checks++; if (busy !== 1'b1 || gnt !== 1'(exp) || m_rsp[exp].ready !== 1'b1) begin
                errors++; $display("FAIL postrst_gnt t=%0d got busy=%0b gnt=%0d exp gnt=%0d", t, busy, gnt, exp);
            end
            m_ptr = next_ptr(exp, 2);
            m_gnt = exp;
            @(posedge clk); #1;
            m_req[exp].valid = 1'b0;
            man_ready = 1'b0;
        end
    endtask

    // One 4-port transaction with request set v; slave answers in the first Busy cycle.
    task automatic run4(input logic [3:0] v);
        int exp;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            m4_req[i] = '{addr: 32'(i * 32'h100), write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: v[i]};
        end
        exp = pick(v, m4_ptr, 4);
        @(negedge clk);
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL wrap_idle v=%b got=%0b exp=0", v, busy4); end
        @(posedge clk); #1;
        s4_rsp.ready = 1'b1;
        @(negedge clk);
        checks++; if (busy4 !== 1'b1 || gnt4 !== 2'(exp)) begin
            errors++; $display("FAIL wrap_gnt v=%b got busy=%0b gnt=%0d exp gnt=%0d", v, busy4, gnt4, exp);
        end
        checks++; if (m4_rsp[exp].ready !== 1'b1 || s4_req.addr !== 32'(exp * 32'h100)) begin
            errors++; $display("FAIL wrap_route v=%b got ready=%0b addr=%0h exp port=%0d", v, m4_rsp[exp].ready, s4_req.addr, exp);
        end
        m4_ptr = next_ptr(exp, 4);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) m4_req[i].valid = 1'b0;
        s4_rsp.ready = 1'b0;
    endtask

    task automatic test_wrap();
        run4(4'b1000);
        run4(4'b0101);
        run4(4'b0101);
        run4(4'b1010);
    endtask

    // Random requests and slave latency against the arbitration model.
    task automatic test_random();
        logic       model_busy;
        logic       hs [2];
        logic [3:0] v;
        int         done;
        int         c;
        int         w;
        model_busy = 1'b0;
        hs[0] = 1'b0;
        hs[1] = 1'b0;
        done = 0;
        c = 0;
        while ((c < 600 || model_busy || m_req[0].valid || m_req[1].valid) && c < 1000) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    m_req[i].valid = 1'b0;
                end else if (!m_req[i].valid && c < 600 && $urandom_range(0, 2) == 0) begin
                    m_req[i] = '{addr: $urandom, write: 1'($urandom), wdata: $urandom, wstrb: 4'($urandom), valid: 1'b1};
                end
            end
            man_ready = ($urandom_range(0, 2) == 0);
            s_rdata   = $urandom;
            s_err     = 1'($urandom);
            @(negedge clk);
            hs[0] = 1'b0;
            hs[1] = 1'b0;
            checks++; if (busy !== model_busy || s_req.valid !== model_busy || gnt !== 1'(m_gnt)) begin
                errors++; $display("FAIL rand_state c=%0d got busy=%0b valid=%0b gnt=%0d exp busy=%0b gnt=%0d", c, busy, s_req.valid, gnt, model_busy, m_gnt);
            end
            for (int i = 0; i < 2; i++) begin
                checks++; if (m_rsp[i].ready !== (model_busy && i == m_gnt && man_ready) || m_rsp[i].rdata !== s_rdata || m_rsp[i].error !== s_err) begin
                    errors++; $display("FAIL rand_rsp c=%0d port=%0d got ready=%0b rdata=%0h", c, i, m_rsp[i].ready, m_rsp[i].rdata);
                end
            end
            if (model_busy) begin
                checks++; if (s_req.addr !== m_req[m_gnt].addr || s_req.wdata !== m_req[m_gnt].wdata || s_req.write !== m_req[m_gnt].write) begin
                    errors++; $display("FAIL rand_fields c=%0d got addr=%0h exp=%0h", c, s_req.addr, m_req[m_gnt].addr);
                end
                if (man_ready) begin
                    model_busy = 1'b0;
                    hs[m_gnt]  = 1'b1;
                    done++;
                end
            end else begin
                v = {2'b00, m_req[1].valid, m_req[0].valid};
                if (v != 4'b0) begin
                    w = pick(v, m_ptr, 2);
                    m_gnt = w;
                    m_ptr = next_ptr(w, 2);
                    model_busy = 1'b1;
                end
            end
            c++;
        end
        checks++; if (c >= 1000) begin errors++; $display("FAIL rand_timeout cycles=%0d limit=1000", c); end
        checks++; if (done < 20) begin errors++; $display("FAIL rand_throughput got=%0d exp>=20", done); end
        man_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_read_routing();
        test_contention();
        test_reset_mid_busy();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
